// File: rtl/ulg_fusion_engine.sv
// ulg_fusion_engine
// Fusion stage of the ULG datapath. For each pixel it reads the P1 vector A
// and the P3 scalar C, then forms out[c] = (A[c]*B[c])*C, where B is the P2
// channel gate latched at start. LANES channels are processed per cycle
// through a two-stage multiply pipeline. Fused vectors are queued in a small
// output FIFO that feeds the encoder over valid/ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_clk_en          global enable; low freezes every register
//   i_start           run start (accepted in IDLE only)
//   i_mode            0: A*B*C  1: A*B  2: A*C  3: A
//   i_pixel_count     pixels in the run
//   i_gate_flat       B vector, latched at start
//   o_p1_rd_*         P1 read strobe/address, data on i_p1_rd_data one cycle later
//   o_p3_rd_*         P3 read strobe/address, data on i_p3_rd_data one cycle later
//   o_enc_*           FIFO head towards the encoder (valid/ready/data/last)
//   o_busy            run in progress
//   o_done            one-cycle pulse after the last pixel has been accepted
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start
// READ   | issue P1/P3 reads for pixel pix once the FIFO has room
// WAIT   | read data arrives, captured into the pixel registers
// COMP   | issue one beat of LANES channels per cycle into stage 1
// DRAIN  | let the pipeline empty, push the assembled vector
// DONE   | wait for the FIFO to empty, pulse o_done
module ulg_fusion_engine #(
  parameter int DATA_W    = 8,
  parameter int IN_CH     = 8,
  parameter int LANES     = 2,
  parameter int FRAC_W    = 4,
  parameter int FM_ADDR_W = 10,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clk_en,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  input  logic [FM_ADDR_W:0]      i_pixel_count,
  input  logic [IN_CH*DATA_W-1:0] i_gate_flat,
  output logic                    o_p1_rd_en,
  output logic [FM_ADDR_W-1:0]    o_p1_rd_addr,
  input  logic [IN_CH*DATA_W-1:0] i_p1_rd_data,
  output logic                    o_p3_rd_en,
  output logic [FM_ADDR_W-1:0]    o_p3_rd_addr,
  input  logic [DATA_W-1:0]       i_p3_rd_data,
  output logic                    o_enc_valid,
  input  logic                    i_enc_ready,
  output logic [IN_CH*DATA_W-1:0] o_enc_data,
  output logic                    o_enc_last,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int VEC_W  = IN_CH * DATA_W;
  localparam int BEATS  = IN_CH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // one guard bit above the full product keeps the rounding add from wrapping
  localparam int PW     = 2 * DATA_W + 1;

  localparam logic signed [PW-1:0] RND_K   = PW'(1) << (FRAC_W - 1);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 << (DATA_W - 1)));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_COMP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]             mode_q;
  logic [FM_ADDR_W:0]     count_q;
  logic [VEC_W-1:0]       gate_q;
  logic [FM_ADDR_W-1:0]   pix_q;
  logic [VEC_W-1:0]       a_q;
  logic [DATA_W-1:0]      c_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   drain_cnt_q;
  logic                   pending_q;

  logic                   s1_valid_q;
  logic [BEAT_W-1:0]      s1_beat_q;
  logic [LANES-1:0][DATA_W-1:0] s1_p_q;
  logic [LANES-1:0][DATA_W-1:0] s1_p_d;
  logic [LANES-1:0][DATA_W-1:0] s2_d;
  logic [VEC_W-1:0]       asm_q;

  logic [VEC_W:0]         fifo_mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       fifo_cnt_q;

  logic stall;
  logic last_beat;
  logic drain_done;
  logic last_pix;
  logic push;
  logic pop;

  // Signed fixed-point multiply: round half toward +inf, then saturate.
  function automatic logic [DATA_W-1:0] fix_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sh;
    prod = $signed({{(PW-DATA_W){a[DATA_W-1]}}, a}) *
           $signed({{(PW-DATA_W){b[DATA_W-1]}}, b});
    sh = (prod + RND_K) >>> FRAC_W;
    if (sh > SAT_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < SAT_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end
    return sh[DATA_W-1:0];
  endfunction

  // A pixel in flight already owns a FIFO slot, so it counts against room.
  assign stall      = (int'(fifo_cnt_q) + int'(pending_q)) >= OUT_DEPTH;
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign drain_done = (drain_cnt_q == 1'b0);
  assign last_pix   = ({1'b0, pix_q} == (count_q - (FM_ADDR_W+1)'(1)));
  assign push       = i_clk_en && (state_q == ST_DRAIN) && drain_done;
  assign pop        = i_clk_en && o_enc_valid && i_enc_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (i_clk_en) begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = (i_pixel_count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (!stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_COMP;
      ST_COMP: begin
        if (last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = last_pix ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        if (fifo_cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (all derived from registers, so they hold while frozen)
  always_comb begin
    o_busy       = (state_q != ST_IDLE);
    o_p1_rd_en   = (state_q == ST_READ) && !stall;
    o_p3_rd_en   = (state_q == ST_READ) && !stall;
    o_p1_rd_addr = pix_q;
    o_p3_rd_addr = pix_q;
    o_done       = (state_q == ST_DONE) && (fifo_cnt_q == '0);
  end

  // Stage 1 operands for the current beat; modes 2/3 bypass the gate.
  always_comb begin
    s1_p_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode_q[1]) begin
        s1_p_d[l] = a_q[(int'(beat_q) * LANES + l) * DATA_W +: DATA_W];
      end else begin
        s1_p_d[l] = fix_mul(a_q[(int'(beat_q) * LANES + l) * DATA_W +: DATA_W],
                            gate_q[(int'(beat_q) * LANES + l) * DATA_W +: DATA_W]);
      end
    end
  end

  // Stage 2 results; modes 1/3 bypass the spatial scalar.
  always_comb begin
    s2_d = '0;
    for (int l = 0; l < LANES; l++) begin
      s2_d[l] = mode_q[0] ? s1_p_q[l] : fix_mul(s1_p_q[l], c_q);
    end
  end

  // Run control and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      count_q     <= '0;
      gate_q      <= '0;
      pix_q       <= '0;
      a_q         <= '0;
      c_q         <= '0;
      beat_q      <= '0;
      drain_cnt_q <= 1'b0;
      pending_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_beat_q   <= '0;
      s1_p_q      <= '0;
      asm_q       <= '0;
    end else if (i_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            mode_q  <= i_mode;
            count_q <= i_pixel_count;
            gate_q  <= i_gate_flat;
            pix_q   <= '0;
          end
        end
        ST_READ: begin
          if (!stall) begin
            pending_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          a_q    <= i_p1_rd_data;
          c_q    <= i_p3_rd_data;
          beat_q <= '0;
        end
        ST_COMP: begin
          beat_q <= beat_q + BEAT_W'(1);
          if (last_beat) begin
            // two DRAIN cycles: stage 2 completes, then the vector is pushed
            drain_cnt_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            pending_q <= 1'b0;
            if (!last_pix) begin
              pix_q <= pix_q + FM_ADDR_W'(1);
            end
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase

      s1_valid_q <= (state_q == ST_COMP);
      if (state_q == ST_COMP) begin
        s1_beat_q <= beat_q;
        s1_p_q    <= s1_p_d;
      end

      if (s1_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          asm_q[(int'(s1_beat_q) * LANES + l) * DATA_W +: DATA_W] <= s2_d[l];
        end
      end
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage: {last, data}
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {last_pix, asm_q};
    end
  end

  // Head is forced to zero when empty so outputs read 0 after reset/flush.
  always_comb begin
    o_enc_valid = (fifo_cnt_q != '0);
    o_enc_data  = o_enc_valid ? fifo_mem_q[rd_ptr_q][VEC_W-1:0] : '0;
    o_enc_last  = o_enc_valid ? fifo_mem_q[rd_ptr_q][VEC_W] : 1'b0;
  end

endmodule

// File: tb/tb_ulg_fusion_engine.sv
module tb_ulg_fusion_engine;

  localparam int DATA_W    = 8;
  localparam int IN_CH     = 8;
  localparam int LANES     = 2;
  localparam int FRAC_W    = 4;
  localparam int FM_ADDR_W = 10;
  localparam int OUT_DEPTH = 2;
  localparam int VEC_W     = IN_CH * DATA_W;
  localparam int BEATS     = IN_CH / LANES;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   i_clk_en = 1'b1;
  logic                   i_start = 1'b0;
  logic [1:0]             i_mode = '0;
  logic [FM_ADDR_W:0]     i_pixel_count = '0;
  logic [VEC_W-1:0]       i_gate_flat = '0;
  logic                   o_p1_rd_en;
  logic [FM_ADDR_W-1:0]   o_p1_rd_addr;
  logic [VEC_W-1:0]       i_p1_rd_data;
  logic                   o_p3_rd_en;
  logic [FM_ADDR_W-1:0]   o_p3_rd_addr;
  logic [DATA_W-1:0]      i_p3_rd_data;
  logic                   o_enc_valid;
  logic                   i_enc_ready = 1'b1;
  logic [VEC_W-1:0]       o_enc_data;
  logic                   o_enc_last;
  logic                   o_busy;
  logic                   o_done;

  ulg_fusion_engine #(
    .DATA_W(DATA_W), .IN_CH(IN_CH), .LANES(LANES), .FRAC_W(FRAC_W),
    .FM_ADDR_W(FM_ADDR_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_clk_en(i_clk_en), .i_start(i_start),
    .i_mode(i_mode), .i_pixel_count(i_pixel_count), .i_gate_flat(i_gate_flat),
    .o_p1_rd_en(o_p1_rd_en), .o_p1_rd_addr(o_p1_rd_addr), .i_p1_rd_data(i_p1_rd_data),
    .o_p3_rd_en(o_p3_rd_en), .o_p3_rd_addr(o_p3_rd_addr), .i_p3_rd_data(i_p3_rd_data),
    .o_enc_valid(o_enc_valid), .i_enc_ready(i_enc_ready), .o_enc_data(o_enc_data),
    .o_enc_last(o_enc_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VEC_W-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    int mode;
    int a;
    int b;
    int c;
    int exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  beat_t exp_q[$];
  int strobe_addr[$];
  int strobe_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  bit valid_seen = 0;
  bit rand_ready = 0;
  bit rand_en = 0;

  logic [VEC_W-1:0]  p1_mem [64];
  logic [DATA_W-1:0] p3_mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous P1/P3 buffers: data one cycle after the strobe.
  always @(posedge clk) begin
    if (o_p1_rd_en) i_p1_rd_data <= p1_mem[o_p1_rd_addr[5:0]];
    if (o_p3_rd_en) i_p3_rd_data <= p3_mem[o_p3_rd_addr[5:0]];
  end

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: round half toward +inf, saturate to DATA_W.
  function automatic int rmul(input int a, input int b);
    int p;
    int maxv;
    maxv = (1 << (DATA_W - 1)) - 1;
    p = (a * b + (1 << (FRAC_W - 1))) >>> FRAC_W;
    if (p > maxv) p = maxv;
    if (p < -maxv - 1) p = -maxv - 1;
    return p;
  endfunction

  function automatic logic [VEC_W-1:0] ref_pixel(input logic [1:0] m,
                                                 input logic [VEC_W-1:0] av,
                                                 input logic [VEC_W-1:0] bv,
                                                 input logic [DATA_W-1:0] cv);
    logic [VEC_W-1:0] r;
    int a, b, c, p, q;
    r = '0;
    c = int'($signed(cv));
    for (int ch = 0; ch < IN_CH; ch++) begin
      a = int'($signed(av[ch*DATA_W +: DATA_W]));
      b = int'($signed(bv[ch*DATA_W +: DATA_W]));
      p = (m == 2'd2 || m == 2'd3) ? a : rmul(a, b);
      q = (m == 2'd1 || m == 2'd3) ? p : rmul(p, c);
      r[ch*DATA_W +: DATA_W] = DATA_W'(q);
    end
    return r;
  endfunction

  // Monitor: scoreboard pops, done pulses, read strobes (enabled cycles only).
  always @(negedge clk) begin
    if (!rst && i_clk_en) begin
      if (o_enc_valid) valid_seen = 1;
      if (o_enc_valid && i_enc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", o_enc_data, '0);
          checks++; failures++;
          $display("FAIL unexpected_beat: beat with empty scoreboard");
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", o_enc_data, e.data);
          check("beat_last", o_enc_last, e.last);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_p1_rd_en || o_p3_rd_en) begin
        check("p3_strobe_match", {o_p3_rd_en, o_p3_rd_addr}, {o_p1_rd_en, o_p1_rd_addr});
        strobe_addr.push_back(int'(o_p1_rd_addr));
        strobe_cyc.push_back(cyc);
      end
    end
  end

  // Random backpressure / enable gaps for the randomized runs.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) i_enc_ready = 1'($urandom_range(0, 1));
      if (rand_en) i_clk_en = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic begin_run();
    strobe_addr.delete();
    strobe_cyc.delete();
    done_cnt = 0;
    valid_seen = 0;
  endtask

  task automatic do_start(input logic [1:0] m, input int cnt);
    i_mode = m;
    i_pixel_count = (FM_ADDR_W+1)'(cnt);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_busy) begin
      failures++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic end_run(input string name, input int strobes);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_strobes"}, strobe_addr.size(), strobes);
  endtask

  task automatic fill_random(input int cnt);
    for (int p = 0; p < cnt; p++) begin
      p1_mem[p] = {$urandom, $urandom};
      p3_mem[p] = DATA_W'($urandom_range(0, 255));
    end
  endtask

  task automatic queue_expect(input logic [1:0] m, input int cnt, input logic [VEC_W-1:0] gate);
    beat_t e;
    for (int p = 0; p < cnt; p++) begin
      e.data = ref_pixel(m, p1_mem[p], gate, p3_mem[p]);
      e.last = (p == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  vec_t tbl[10];
  logic [VEC_W-1:0] gate;
  beat_t e;

  initial begin
    int n;
    int m;
    int cnt;

    tbl[0] = '{0,   32,  24,   8,   24};
    tbl[1] = '{1,  127, 127,   0,  127};
    tbl[2] = '{1, -128, 127,   0, -128};
    tbl[3] = '{1,    3,   8,   0,    2};
    tbl[4] = '{1,   -3,   8,   0,   -1};
    tbl[5] = '{1,    1,   8,   0,    1};
    tbl[6] = '{2,   16,   0,  -8,   -8};
    tbl[7] = '{3,   -5,  99,  77,   -5};
    tbl[8] = '{0,  -16, -16,  16,   16};
    tbl[9] = '{2,  100,   0, 100,  127};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_enc_valid, 0);
    check("rst_strobes", {o_p1_rd_en, o_p3_rd_en}, 0);
    check("rst_addr", {o_p1_rd_addr, o_p3_rd_addr}, 0);
    check("rst_done", o_done, 0);
    check("rst_data", {o_enc_last, o_enc_data}, 0);
    @(posedge clk); #1;

    // Table-driven single-pixel runs
    for (int i = 0; i < 10; i++) begin
      begin_run();
      p1_mem[0] = {IN_CH{DATA_W'(tbl[i].a)}};
      p3_mem[0] = DATA_W'(tbl[i].c);
      i_gate_flat = {IN_CH{DATA_W'(tbl[i].b)}};
      e.data = {IN_CH{DATA_W'(tbl[i].exp)}};
      e.last = 1'b1;
      exp_q.push_back(e);
      do_start(2'(tbl[i].mode), 1);
      wait_idle("table", 100);
      end_run("table", 1);
    end

    // Three pixels, full throughput, last on the third
    begin_run();
    for (int p = 0; p < 3; p++) begin
      p1_mem[p] = {IN_CH{8'd32}};
      p3_mem[p] = 8'd8;
      e.data = {IN_CH{8'd24}};
      e.last = (p == 2);
      exp_q.push_back(e);
    end
    i_gate_flat = {IN_CH{8'd24}};
    do_start(2'd0, 3);
    wait_idle("three_pix", 200);
    end_run("three_pix", 3);
    if (strobe_cyc.size() == 3) begin
      check("pix_period_0", strobe_cyc[1] - strobe_cyc[0], BEATS + 4);
      check("pix_period_1", strobe_cyc[2] - strobe_cyc[1], BEATS + 4);
      check("three_pix_addr", {strobe_addr[0], strobe_addr[1], strobe_addr[2]}, {32'd0, 32'd1, 32'd2});
    end

    // FIFO reservation under backpressure
    begin_run();
    i_enc_ready = 1'b0;
    fill_random(5);
    gate = {$urandom, $urandom};
    i_gate_flat = gate;
    queue_expect(2'd0, 5, gate);
    do_start(2'd0, 5);
    repeat (100) @(posedge clk);
    #1;
    check("bp_strobes", strobe_addr.size(), OUT_DEPTH);
    if (strobe_addr.size() >= 2) check("bp_addr", {strobe_addr[0], strobe_addr[1]}, {32'd0, 32'd1});
    check("bp_head_valid", o_enc_valid, 1);
    check("bp_head_data", o_enc_data, exp_q[0].data);
    check("bp_head_last", o_enc_last, 0);
    i_enc_ready = 1'b1;
    wait_idle("bp", 300);
    end_run("bp", 5);
    if (strobe_addr.size() == 5) check("bp_order", strobe_addr[4], 4);

    // Zero-pixel run
    begin_run();
    n = cyc;
    do_start(2'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_done_pulses", done_cnt, 1);
    check("zero_done_latency", (done_cyc - n) <= 2, 1);
    check("zero_strobes", strobe_addr.size(), 0);
    check("zero_valid", valid_seen, 0);

    // Start while busy is ignored (gate is latched, mode/count too)
    begin_run();
    fill_random(2);
    gate = {$urandom, $urandom};
    i_gate_flat = gate;
    queue_expect(2'd1, 2, gate);
    do_start(2'd1, 2);
    repeat (5) @(posedge clk);
    #1;
    i_gate_flat = ~gate;
    do_start(2'd3, 5);
    wait_idle("busy_start", 200);
    end_run("busy_start", 2);

    // Freeze mid-COMP
    begin_run();
    fill_random(2);
    gate = {$urandom, $urandom};
    i_gate_flat = gate;
    queue_expect(2'd0, 2, gate);
    do_start(2'd0, 2);
    n = 0;
    while (strobe_cyc.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("freeze_first_strobe", strobe_cyc.size(), 1);
    repeat (2) @(posedge clk);
    #1;
    i_clk_en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("freeze_busy", o_busy, 1);
    check("freeze_no_strobe", o_p1_rd_en, 0);
    @(posedge clk); #1;
    i_clk_en = 1'b1;
    wait_idle("freeze", 200);
    end_run("freeze", 2);

    // Reset mid-run
    begin_run();
    i_enc_ready = 1'b0;
    fill_random(4);
    gate = {$urandom, $urandom};
    i_gate_flat = gate;
    do_start(2'd0, 4);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    begin_run();
    @(negedge clk);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_valid", o_enc_valid, 0);
    check("mid_rst_outputs", {o_p1_rd_en, o_p3_rd_en, o_done, o_enc_last, o_p1_rd_addr}, 0);
    check("mid_rst_data", o_enc_data, 0);
    i_enc_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_beats", valid_seen, 0);

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      begin_run();
      m = $urandom_range(0, 3);
      cnt = $urandom_range(1, 6);
      fill_random(cnt);
      gate = {$urandom, $urandom};
      i_gate_flat = gate;
      queue_expect(2'(m), cnt, gate);
      do_start(2'(m), cnt);
      rand_ready = 1;
      rand_en = 1;
      wait_idle("rand", 2000);
      rand_ready = 0;
      rand_en = 0;
      i_clk_en = 1'b1;
      i_enc_ready = 1'b1;
      @(posedge clk); #1;
      end_run("rand", cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
